// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave backed by a word-addressed SRAM model.
// Programmable wait states, two-cycle ERROR, write-to-read forwarding.
module ahb_sram_slave #(
  parameter int ADDRW       = 32,
  parameter int DATAW       = 256,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsel,
  input  logic [ADDRW-1:0] haddr,
  input  logic             hwrite,
  input  logic [2:0]       hsize,
  input  logic [2:0]       hburst,
  input  logic [1:0]       htrans,
  input  logic [DATAW-1:0] hwdata,
  output logic             hready,
  output logic             hresp,
  output logic [DATAW-1:0] hrdata
);

  localparam int LSB  = $clog2(DATAW/8);
  localparam int IDXW = $clog2(DEPTH);
  localparam logic [ADDRW-1:0] DEPTH_A = ADDRW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t state, state_nx;

  logic [3:0]       cnt, cnt_nx;
  logic [IDXW-1:0]  idx_q, idx_in;
  logic             wr_q;
  logic             accept, err_in;
  logic             mem_we, fwd;
  logic [DATAW-1:0] mem [DEPTH];
  logic             unused_in;

  assign unused_in = ^{hburst, htrans[0]};

  assign idx_in = haddr[LSB +: IDXW];
  assign accept = hsel && hready && htrans[1];
  assign err_in = (|haddr[LSB-1:0])
               || ((haddr >> LSB) >= DEPTH_A)
               || (hsize != 3'(LSB));

  assign hready = !(state inside {S_WAIT, S_ERR1});
  assign hresp  = state inside {S_ERR1, S_ERR2};

  // A read accepted while a same-word write closes sees the bus data.
  assign mem_we = (state == S_DATA) && wr_q;
  assign fwd    = mem_we && (idx_q == idx_in);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      S_WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = S_DATA;
      end
      S_ERR1: state_nx = S_ERR2;
      default: begin
        state_nx = S_IDLE;
        if (accept) begin
          if (err_in) begin
            state_nx = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nx = S_WAIT;
            cnt_nx   = 4'(WAIT_STATES);
          end else begin
            state_nx = S_DATA;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx_q  <= '0;
      wr_q   <= 1'b0;
      hrdata <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        idx_q <= idx_in;
        wr_q  <= hwrite && !err_in;
        if (!hwrite && !err_in)
          hrdata <= fwd ? hwdata : mem[idx_in];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= hwdata;
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave.
// Two instances: zero wait states and two wait states.
module tb_ahb_sram_slave;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         use2 = 1'b0;
  logic         hsel = 1'b0;
  logic [31:0]  haddr = '0;
  logic         hwrite = 1'b0;
  logic [2:0]   hsize = 3'd5;
  logic [2:0]   hburst = 3'd0;
  logic [1:0]   htrans = 2'd0;
  logic [255:0] hwdata = '0;

  logic         hsel_a, hsel_b;
  logic         hready_a, hready_b, hresp_a, hresp_b;
  logic [255:0] hrdata_a, hrdata_b;
  logic         hready, hresp;
  logic [255:0] hrdata;

  int total = 0;
  int bad = 0;

  assign hsel_a = hsel & ~use2;
  assign hsel_b = hsel & use2;
  assign hready = use2 ? hready_b : hready_a;
  assign hresp  = use2 ? hresp_b : hresp_a;
  assign hrdata = use2 ? hrdata_b : hrdata_a;

  always #5 clk = ~clk;

  ahb_sram_slave #(.WAIT_STATES(0)) dut_a (
    .clk(clk), .rst(rst), .hsel(hsel_a), .haddr(haddr),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .htrans(htrans), .hwdata(hwdata), .hready(hready_a),
    .hresp(hresp_a), .hrdata(hrdata_a)
  );

  ahb_sram_slave #(.WAIT_STATES(2)) dut_b (
    .clk(clk), .rst(rst), .hsel(hsel_b), .haddr(haddr),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .htrans(htrans), .hwdata(hwdata), .hready(hready_b),
    .hresp(hresp_b), .hrdata(hrdata_b)
  );

  task automatic xfer(
    input  logic [31:0]  a,
    input  logic         wr,
    input  logic [2:0]   sz,
    input  logic [255:0] wd,
    output logic [255:0] rd,
    output int           waits,
    output logic         r0,
    output logic         r1
  );
    hsel = 1'b1; htrans = 2'd2; hwrite = wr;
    haddr = a; hsize = sz; hburst = 3'd0;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'd0; hwdata = wd;
    waits = 0; r0 = hresp;
    while (!hready && waits < 40) begin
      @(posedge clk); #1;
      waits++;
    end
    r1 = hresp; rd = hrdata;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    if (hready_a !== 1'b1 || hready_b !== 1'b1) begin
      bad++; $display("FAIL rst_hready got=%b%b exp=11", hready_a, hready_b);
    end
    total++;
    if (hresp_a !== 1'b0 || hresp_b !== 1'b0) begin
      bad++; $display("FAIL rst_hresp got=%b%b exp=00", hresp_a, hresp_b);
    end
    total++;
    if (hrdata_a !== '0 || hrdata_b !== '0) begin
      bad++; $display("FAIL rst_hrdata got=%h exp=0", hrdata_a | hrdata_b);
    end
    total++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    logic [255:0] rd; int w; logic r0, r1;
    use2 = 1'b0;
    xfer(32'h40, 1'b1, 3'd5, {32{8'hA5}}, rd, w, r0, r1);
    if (w !== 0 || r1 !== 1'b0) begin
      bad++; $display("FAIL t1_wr got waits=%0d resp=%b exp 0/0", w, r1);
    end
    total++;
    xfer(32'h40, 1'b0, 3'd5, '0, rd, w, r0, r1);
    if (rd !== {32{8'hA5}}) begin
      bad++; $display("FAIL t1_rd_data got=%h exp=%h", rd, {32{8'hA5}});
    end
    total++;
    if (w !== 0 || r1 !== 1'b0) begin
      bad++; $display("FAIL t1_rd got waits=%0d resp=%b exp 0/0", w, r1);
    end
    total++;
  endtask

  task automatic test_incr4;
    logic [255:0] rd; int w; logic r0, r1;
    int beats, cyc, run;
    int lows [4];
    use2 = 1'b1;
    hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1;
    haddr = 32'h100; hsize = 3'd5; hburst = 3'd3;
    @(posedge clk); #1;
    beats = 0; cyc = 0; run = 0;
    while (beats < 4 && cyc < 40) begin
      hwdata = {32{8'h10 + 8'(beats)}};
      if (beats < 3) begin
        haddr = 32'h100 + 32'(32 * (beats + 1));
        htrans = 2'd3; hsel = 1'b1;
      end else begin
        htrans = 2'd0; hsel = 1'b0;
      end
      if (hready) begin
        lows[beats] = run; run = 0; beats++;
      end else begin
        run++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    hburst = 3'd0;
    if (cyc !== 12) begin
      bad++; $display("FAIL t2_cycles got=%0d exp=12", cyc);
    end
    total++;
    for (int i = 0; i < 4; i++) begin
      if (lows[i] !== 2) begin
        bad++; $display("FAIL t2_lows beat%0d got=%0d exp=2", i, lows[i]);
      end
      total++;
    end
    for (int i = 0; i < 4; i++) begin
      xfer(32'h100 + 32'(32 * i), 1'b0, 3'd5, '0, rd, w, r0, r1);
      if (rd !== {32{8'h10 + 8'(i)}} || w !== 2) begin
        bad++; $display("FAIL t2_word%0d got=%h waits=%0d", 8 + i, rd, w);
      end
      total++;
    end
  endtask

  task automatic test_errors;
    logic [255:0] rd; int w; logic r0, r1;
    use2 = 1'b0;
    xfer(32'h100, 1'b1, 3'd5, {32{8'hC3}}, rd, w, r0, r1);
    xfer(32'h104, 1'b1, 3'd5, {32{8'h3C}}, rd, w, r0, r1);
    if (r0 !== 1'b1 || r1 !== 1'b1 || w !== 1) begin
      bad++; $display("FAIL t3_misalign got r=%b%b w=%0d exp 11/1", r0, r1, w);
    end
    total++;
    xfer(32'h100, 1'b0, 3'd5, '0, rd, w, r0, r1);
    if (rd !== {32{8'hC3}} || r1 !== 1'b0) begin
      bad++; $display("FAIL t3_rd got=%h resp=%b exp=%h", rd, r1, {32{8'hC3}});
    end
    total++;
    xfer(32'h0, 1'b1, 3'd5, {32{8'h5A}}, rd, w, r0, r1);
    xfer(32'h8000, 1'b1, 3'd5, {32{8'hFF}}, rd, w, r0, r1);
    if (r0 !== 1'b1 || r1 !== 1'b1 || w !== 1) begin
      bad++; $display("FAIL t4_range got r=%b%b w=%0d exp 11/1", r0, r1, w);
    end
    total++;
    xfer(32'h0, 1'b0, 3'd5, '0, rd, w, r0, r1);
    if (rd !== {32{8'h5A}}) begin
      bad++; $display("FAIL t4_rd got=%h exp=%h", rd, {32{8'h5A}});
    end
    total++;
    xfer(32'h40, 1'b0, 3'd2, '0, rd, w, r0, r1);
    if (r0 !== 1'b1 || r1 !== 1'b1) begin
      bad++; $display("FAIL t_hsize got r=%b%b exp=11", r0, r1);
    end
    total++;
  endtask

  task automatic test_back_to_back;
    logic [255:0] rd; int w; logic r0, r1;
    use2 = 1'b0;
    xfer(32'h20, 1'b1, 3'd5, {32{8'h77}}, rd, w, r0, r1);
    hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1;
    haddr = 32'h20; hsize = 3'd5;
    @(posedge clk); #1;
    hwdata = {32{8'h11}}; hwrite = 1'b0; htrans = 2'd2;
    if (hready !== 1'b1) begin
      bad++; $display("FAIL t5_wr_hready got=%b exp=1", hready);
    end
    total++;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'd0;
    if (hready !== 1'b1 || hresp !== 1'b0 || hrdata !== {32{8'h11}}) begin
      bad++; $display("FAIL t5_fwd got=%h rdy=%b resp=%b exp=%h",
                      hrdata, hready, hresp, {32{8'h11}});
    end
    total++;
    @(posedge clk); #1;
    xfer(32'h20, 1'b0, 3'd5, '0, rd, w, r0, r1);
    if (rd !== {32{8'h11}}) begin
      bad++; $display("FAIL t5_commit got=%h exp=%h", rd, {32{8'h11}});
    end
    total++;
  endtask

  task automatic test_mid_reset;
    logic [255:0] rd; int w; logic r0, r1;
    use2 = 1'b1;
    xfer(32'h60, 1'b1, 3'd5, {32{8'h33}}, rd, w, r0, r1);
    xfer(32'h100, 1'b0, 3'd5, '0, rd, w, r0, r1);
    hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1;
    haddr = 32'h60; hsize = 3'd5;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'd0; hwdata = {32{8'h99}};
    if (hready !== 1'b0 || hrdata === '0) begin
      bad++; $display("FAIL t6_pre got rdy=%b data=%h exp rdy=0 data!=0", hready, hrdata);
    end
    total++;
    rst = 1'b0;
    #1;
    if (hready !== 1'b1 || hresp !== 1'b0 || hrdata !== '0) begin
      bad++; $display("FAIL t6_rst got rdy=%b resp=%b data=%h exp 1/0/0",
                      hready, hresp, hrdata);
    end
    total++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    xfer(32'h60, 1'b0, 3'd5, '0, rd, w, r0, r1);
    if (rd !== {32{8'h33}}) begin
      bad++; $display("FAIL t6_word3 got=%h exp=%h", rd, {32{8'h33}});
    end
    total++;
  endtask

  initial begin
    #2;
    test_reset;
    test_single;
    test_incr4;
    test_errors;
    test_back_to_back;
    test_mid_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
